// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the loader FSM encoding and the stream framing constants used by
// imem_boot_loader and byte_packer. S_CKSUM is only entered when the top is
// built with LOADER_CKSUM_EN defined.
package loader_pkg;

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CKSUM  = 3'd3,
      S_DELAY  = 3'd4,
      S_RUN    = 3'd5,
      S_ERR    = 3'd6
   } state_e;

   // Stream framing: 2 big-endian length bytes, then 4 bytes per word.
   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int PACK_CNT_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit big-endian words (first byte -> [31:24]).
// Latency: word_o/word_done_o are combinational on the accepted 4th byte.
// Backpressure: none; it only advances when take_i is high, so stalls just hold the count.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (drops any partial word)
//   take_i         a data byte is being accepted this cycle
//   byte_i         the accepted byte
//   word_o         packed word, valid while word_done_o is high
//   word_done_o    high in the cycle the final byte of a word is accepted
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        take_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);

   localparam int SH_W = 8 * (WORD_BYTES - 1);

   logic [PACK_CNT_W-1:0] cnt_q, cnt_d;
   logic [SH_W-1:0]       sh_q, sh_d;
   logic                  last_byte;

   assign last_byte   = (cnt_q == PACK_CNT_W'(WORD_BYTES - 1));
   assign word_done_o = take_i && last_byte;
   // The 4th byte is not stored; it is appended directly to form the word.
   assign word_o      = {sh_q, byte_i};

   always_comb begin
      cnt_d = cnt_q;
      sh_d  = sh_q;
      if (take_i) begin
         sh_d  = {sh_q[SH_W-9:0], byte_i};
         cnt_d = last_byte ? '0 : cnt_q + PACK_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program image from a host byte port into instruction memory, then releases the CPU.
// Latency: imem write registered one cycle after a word's last byte; cpu_start_o rises RELEASE_DELAY+1 cycles after the final byte.
// Backpressure: byte_ready_o is a pure function of state (high while loading or draining errors, low in delay/run/reset).
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   byte_valid_i/_data_i/byte_ready_o   host byte interface (accept on valid && ready)
//   imem_we_o, imem_addr_o, imem_wdata_o   one-cycle write strobe, word address, word
//   cpu_start_o       0 holds the CPU in reset, 1 lets it run (sticky until reset)
//   load_err_o        sticky error (length too large, or bad checksum)
//   words_loaded_o    words written so far
// Build option: define LOADER_CKSUM_EN to require a trailing XOR checksum byte
// covering both length bytes and all data bytes.
module imem_boot_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W        = 5,
   parameter int RELEASE_DELAY = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_start_o,
   output logic              load_err_o,
   output logic [ADDR_W:0]   words_loaded_o
);

   localparam int DLY_W = $clog2(RELEASE_DELAY + 1);
   localparam int CNT_W = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [7:0]        len_hi_q, len_hi_d;
   logic [15:0]       len_q, len_d;
   logic [CNT_W-1:0]  words_q, words_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
`ifdef LOADER_CKSUM_EN
   logic [7:0]        ck_q, ck_d;
`endif

   logic              accept;
   logic              pack_take;
   logic              word_done;
   logic [31:0]       pack_word;
   logic [15:0]       len_rx;
   logic              len_too_big;
   logic              last_word;

   assign byte_ready_o = !rst_i &&
                         (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CKSUM, S_ERR});
   assign accept       = byte_valid_i && byte_ready_o;
   assign pack_take    = accept && (state_q == S_DATA);

   // Word count as it would be once the low length byte is taken.
   assign len_rx      = {len_hi_q, byte_data_i};
   assign len_too_big = (17'(len_rx) > (17'd1 << ADDR_W));
   assign last_word   = ((16'(words_q) + 16'd1) == len_q);

   byte_packer u_packer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .take_i      (pack_take),
      .byte_i      (byte_data_i),
      .word_o      (pack_word),
      .word_done_o (word_done)
   );

   // The delay counter is loaded on the same edge the last write is
   // registered and runs down to zero; S_RUN is entered one edge after it
   // reaches zero, so the write cycle plus RELEASE_DELAY cycles elapse
   // between the final byte and the CPU release.
   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      len_d    = len_q;
      words_d  = words_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      dly_d    = dly_q;
`ifdef LOADER_CKSUM_EN
      ck_d     = ck_q;
      if (accept && (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA})) begin
         ck_d = ck_q ^ byte_data_i;
      end
`endif

      case (state_q)
         S_LEN_HI: begin
            if (accept) begin
               len_hi_d = byte_data_i;
               state_d  = S_LEN_LO;
            end
         end

         S_LEN_LO: begin
            if (accept) begin
               len_d = len_rx;
               if (len_too_big) begin
                  state_d = S_ERR;
               end else if (len_rx == 16'd0) begin
`ifdef LOADER_CKSUM_EN
                  state_d = S_CKSUM;
`else
                  state_d = S_DELAY;
                  dly_d   = DLY_W'(RELEASE_DELAY);
`endif
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (word_done) begin
               we_d    = 1'b1;
               addr_d  = words_q[ADDR_W-1:0];
               wdata_d = pack_word;
               words_d = words_q + CNT_W'(1);
               if (last_word) begin
`ifdef LOADER_CKSUM_EN
                  state_d = S_CKSUM;
`else
                  state_d = S_DELAY;
                  dly_d   = DLY_W'(RELEASE_DELAY);
`endif
               end
            end
         end

`ifdef LOADER_CKSUM_EN
         S_CKSUM: begin
            if (accept) begin
               if (byte_data_i == ck_q) begin
                  state_d = S_DELAY;
                  dly_d   = DLY_W'(RELEASE_DELAY);
               end else begin
                  state_d = S_ERR;
               end
            end
         end
`endif

         S_DELAY: begin
            if (dly_q == '0) begin
               state_d = S_RUN;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end

         S_RUN, S_ERR: begin
            // Terminal until reset; S_ERR keeps draining bytes via byte_ready_o.
         end

         default: begin
            state_d = S_LEN_HI;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_LEN_HI;
         len_hi_q <= '0;
         len_q    <= '0;
         words_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         dly_q    <= '0;
`ifdef LOADER_CKSUM_EN
         ck_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         len_hi_q <= len_hi_d;
         len_q    <= len_d;
         words_q  <= words_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         dly_q    <= dly_d;
`ifdef LOADER_CKSUM_EN
         ck_q     <= ck_d;
`endif
      end
   end

   assign imem_we_o      = we_q;
   assign imem_addr_o    = addr_q;
   assign imem_wdata_o   = wdata_q;
   assign cpu_start_o    = (state_q == S_RUN);
   assign load_err_o     = (state_q == S_ERR);
   assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (default build, no checksum trailer).
// Latency: n/a.
// Backpressure: n/a.
module tb_imem_boot_loader;

   localparam int ADDR_W = 5;
   localparam int RD     = 4;
   localparam int CAP    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              byte_valid_i = 1'b0;
   logic [7:0]        byte_data_i = 8'h00;
   logic              byte_ready_o;
   logic              imem_we_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_wdata_o;
   logic              cpu_start_o;
   logic              load_err_o;
   logic [ADDR_W:0]   words_loaded_o;

   always #5 clk = ~clk;

   imem_boot_loader #(.ADDR_W(ADDR_W), .RELEASE_DELAY(RD)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .byte_valid_i   (byte_valid_i),
      .byte_data_i    (byte_data_i),
      .byte_ready_o   (byte_ready_o),
      .imem_we_o      (imem_we_o),
      .imem_addr_o    (imem_addr_o),
      .imem_wdata_o   (imem_wdata_o),
      .cpu_start_o    (cpu_start_o),
      .load_err_o     (load_err_o),
      .words_loaded_o (words_loaded_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] img [64];

   // Write log captured from the memory port.
   int          wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   int          dup_cnt = 0;
   logic        prev_we = 1'b0;

   always @(negedge clk) begin
      if (imem_we_o) begin
         wr_addr_q.push_back(int'(imem_addr_o));
         wr_data_q.push_back(imem_wdata_o);
         if (prev_we) dup_cnt++;
      end
      prev_we = imem_we_o;
   end

   typedef struct {
      logic [15:0] n;
      int          stall;
      bit          spec_img;
      bit          exp_err;
      int          exp_writes;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      dup_cnt = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_i        = 1'b1;
      byte_valid_i = 1'b0;
      @(negedge clk);
      check("rst_ready", byte_ready_o, 0);
      @(posedge clk);
      @(negedge clk);
      check("rst_start",  cpu_start_o, 0);
      check("rst_we",     imem_we_o, 0);
      check("rst_err",    load_err_o, 0);
      check("rst_words",  words_loaded_o, 0);
      check("rst_addr",   imem_addr_o, 0);
      check("rst_wdata",  imem_wdata_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("post_rst_ready", byte_ready_o, 1);
      @(posedge clk); #1;
   endtask

   // Offers a byte after 'stall' idle cycles; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int stall);
      bit done = 0;
      byte_valid_i = 1'b0;
      repeat (stall) begin
         @(posedge clk); #1;
      end
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (byte_ready_o) done = 1;
         @(posedge clk); #1;
      end
      byte_valid_i = 1'b0;
      if (!done) check("byte_accept_timeout", 0, 1);
   endtask

   // Streams an image of length n from img[] and checks the outcome against
   // the loader's rules: reject n > capacity, otherwise write img[i] to
   // address i and release the CPU RD+1 cycles after the last byte.
   task automatic run_load(input logic [15:0] n, input int stall);
      bit exp_err;
      int exp_writes;
      int nw;
      bit any_start;
      bit any_we;
      exp_err    = (int'(n) > CAP);
      exp_writes = exp_err ? 0 : int'(n);

      send_byte(n[15:8], stall);
      send_byte(n[7:0], stall);
      if (!exp_err) begin
         for (int w = 0; w < int'(n); w++)
            for (int b = 0; b < 4; b++)
               send_byte(8'(img[w] >> (24 - 8 * b)), stall);
         // Negedge i follows edge k+i, where k accepted the final byte.
         for (int i = 0; i <= RD + 1; i++) begin
            @(negedge clk);
            if (i == 0) check("last_we_pulse", imem_we_o, (n != 0));
            if (i == 1) check("we_single_cycle", imem_we_o, 0);
            if (i == RD) check("start_not_early", cpu_start_o, 0);
            if (i == RD + 1) check("start_on_time", cpu_start_o, 1);
         end
         // Released: further bytes must be refused.
         @(posedge clk); #1;
         byte_valid_i = 1'b1;
         byte_data_i  = 8'h5A;
         nw = wr_addr_q.size();
         repeat (4) begin
            @(negedge clk);
            check("run_ready_low", byte_ready_o, 0);
         end
         @(posedge clk); #1;
         byte_valid_i = 1'b0;
         check("run_no_writes", wr_addr_q.size(), nw);
      end else begin
         @(negedge clk);
         check("err_drain_ready", byte_ready_o, 1);
         @(posedge clk); #1;
         for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
         any_start = 0;
         any_we    = 0;
         repeat (100) begin
            @(negedge clk);
            any_start |= cpu_start_o;
            any_we    |= imem_we_o;
         end
         check("err_start_held", any_start, 0);
         check("err_no_we", any_we, 0);
         @(posedge clk); #1;
      end

      @(negedge clk);
      check("load_err", load_err_o, exp_err);
      check("cpu_start", cpu_start_o, !exp_err);
      check("words_loaded", words_loaded_o, exp_writes);
      check("write_count", wr_addr_q.size(), exp_writes);
      for (int i = 0; i < exp_writes && i < wr_addr_q.size(); i++) begin
         check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], i);
         check($sformatf("wr_data[%0d]", i), wr_data_q[i], img[i]);
      end
      check("dup_strobes", dup_cnt, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #800us;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      //            n       stall spec err writes
      vecs[0] = '{16'd3,    0,    1,   0,  3};
      vecs[1] = '{16'd3,    2,    1,   0,  3};
      vecs[2] = '{16'd0,    0,    0,   0,  0};
      vecs[3] = '{16'h0021, 0,    0,   1,  0};
      vecs[4] = '{16'd32,   0,    0,   0,  32};
      vecs[5] = '{16'd1,    1,    0,   0,  1};
      vecs[6] = '{16'h0100, 1,    0,   1,  0};

      for (int v = 0; v < 7; v++) begin
         do_reset();
         clear_log();
         if (vecs[v].spec_img) begin
            img[0] = 32'h20010005;
            img[1] = 32'h20020007;
            img[2] = 32'h00221820;
         end else begin
            for (int i = 0; i < 64; i++) img[i] = $urandom;
         end
         run_load(vecs[v].n, vecs[v].stall);
         check($sformatf("tbl%0d_err", v), load_err_o, vecs[v].exp_err);
         check($sformatf("tbl%0d_writes", v), wr_addr_q.size(), vecs[v].exp_writes);
      end

      // Reset in the middle of the second word of a two-word image.
      do_reset();
      clear_log();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      repeat (3) @(negedge clk);
      check("midrst_writes_before", wr_addr_q.size(), 1);
      if (wr_addr_q.size() > 0) check("midrst_first_word", wr_data_q[0], 32'h11223344);
      check("midrst_words", words_loaded_o, 1);
      do_reset();
      check("midrst_no_partial_write", wr_addr_q.size(), 1);
      clear_log();
      img[0] = 32'hAC010000;
      run_load(16'd1, 0);

      // Reset while running must hold the CPU again.
      do_reset();
      check("rerun_start_low", cpu_start_o, 0);

      // Randomized images, lengths straddling the capacity limit.
      for (int r = 0; r < 10; r++) begin
         logic [15:0] n;
         int          st;
         n  = 16'($urandom_range(0, CAP + 2));
         st = $urandom_range(0, 2);
         for (int i = 0; i < 64; i++) img[i] = $urandom;
         do_reset();
         clear_log();
         run_load(n, st);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
